// File: rtl/add_pkg.sv
// Shared types and constants for the operand adder stage and its consumers.
package add_pkg;

  localparam int IN_W          = 4;
  localparam int SUM_W         = IN_W + 1;
  localparam int COUNT_DEFAULT = 8;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } acc_state_e;

  typedef logic [IN_W-1:0]  operand_t;
  typedef logic [SUM_W-1:0] sum_t;

  // Zero-extended add at the package's default widths.
  function automatic sum_t add_operands(input operand_t op_a, input operand_t op_b);
    return {1'b0, op_a} + {1'b0, op_b};
  endfunction

endpackage

// File: rtl/add_sum_reg.sv
// Registered a+b with a one-cycle y_valid pulse per enabled cycle.
// clear has priority and suppresses both the update and the pulse.
module add_sum_reg #(
  parameter  int IN_W  = 4,
  localparam int SUM_W = IN_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             en,
  input  logic [IN_W-1:0]  a,
  input  logic [IN_W-1:0]  b,
  output logic [SUM_W-1:0] y,
  output logic             y_valid
);

  import add_pkg::*;

  // Capture the zero-extended sum on enable; y holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y       <= '0;
      y_valid <= 1'b0;
    end else if (clear) begin
      y_valid <= 1'b0;
    end else if (en) begin
      y       <= {1'b0, a} + {1'b0, b};
      y_valid <= 1'b1;
    end else begin
      y_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/add_block_accumulator.sv
// Accepts operand pairs, registers each sum, and totals COUNT sums per block.
// The block total is offered downstream and held until it is taken.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A producer keeps valid and its data stable until the transfer;
// ready never depends on valid. Here in_ready decodes state only, and
// out_valid/acc_out are registered and stay unchanged while out_ready is low.
module add_block_accumulator #(
  parameter  int IN_W  = add_pkg::IN_W,
  parameter  int COUNT = add_pkg::COUNT_DEFAULT,
  localparam int SUM_W = IN_W + 1,
  localparam int CNT_W = $clog2(COUNT),
  localparam int ACC_W = SUM_W + CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_W-1:0]    a,
  input  logic [IN_W-1:0]    b,
  output logic [SUM_W-1:0]   y,
  output logic               y_valid,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   acc_out,
  output logic [CNT_W-1:0]   sample_cnt,
  output add_pkg::acc_state_e state_dbg
);

  import add_pkg::*;

  acc_state_e       state;
  logic             accept;
  logic             last;
  logic [SUM_W-1:0] sum;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_next;

  assign in_ready  = (state == ACCUM);
  assign accept    = in_valid && in_ready;
  assign sum       = {1'b0, a} + {1'b0, b};
  assign acc_next  = acc + ACC_W'(sum);
  assign last      = (sample_cnt == CNT_W'(COUNT - 1));
  assign state_dbg = state;

  add_sum_reg #(
    .IN_W (IN_W)
  ) u_sum_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear),
    .en      (accept),
    .a       (a),
    .b       (b),
    .y       (y),
    .y_valid (y_valid)
  );

  // Block FSM: count and accumulate accepted sums, then hold the total in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ACCUM;
      acc        <= '0;
      acc_out    <= '0;
      sample_cnt <= '0;
      out_valid  <= 1'b0;
    end else if (clear) begin
      // acc_out keeps its stale value; only out_valid marks it as live.
      state      <= ACCUM;
      acc        <= '0;
      sample_cnt <= '0;
      out_valid  <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            acc <= acc_next;
            if (last) begin
              acc_out    <= acc_next;
              sample_cnt <= '0;
              out_valid  <= 1'b1;
              state      <= DONE;
            end else begin
              sample_cnt <= sample_cnt + 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            acc       <= '0;
            out_valid <= 1'b0;
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_add_block_accumulator.sv
// Directed and randomized bench for add_block_accumulator.
module tb_add_block_accumulator;

  localparam int IN_W  = 4;
  localparam int COUNT = 8;
  localparam int SUM_W = 5;
  localparam int CNT_W = 3;
  localparam int ACC_W = 8;

  // ---------------- clock / reset ----------------
  logic clk       = 1'b0;
  logic rst_n     = 1'b0;
  logic clear     = 1'b0;
  logic in_valid  = 1'b0;
  logic out_ready = 1'b0;
  logic [IN_W-1:0] a = '0;
  logic [IN_W-1:0] b = '0;

  logic               in_ready;
  logic [SUM_W-1:0]   y;
  logic               y_valid;
  logic               out_valid;
  logic [ACC_W-1:0]   acc_out;
  logic [CNT_W-1:0]   sample_cnt;
  add_pkg::acc_state_e state_dbg;

  always #5 clk = ~clk;

  add_block_accumulator #(
    .IN_W  (IN_W),
    .COUNT (COUNT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .y          (y),
    .y_valid    (y_valid),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .acc_out    (acc_out),
    .sample_cnt (sample_cnt),
    .state_dbg  (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [ACC_W-1:0] exp_q[$];

  // Reference model, driven only by the bench's own inputs.
  bit m_done = 0;
  bit m_yv   = 0;
  bit m_ov   = 0;
  bit hs     = 0;
  int m_acc = 0, m_cnt = 0, m_y = 0, m_acc_out = 0, hs_val = 0, blocks = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_done = 0; m_yv = 0; m_ov = 0; hs = 0;
      m_acc = 0; m_cnt = 0; m_y = 0; m_acc_out = 0;
      exp_q.delete();
    end else begin
      hs = 0;
      if (clear) begin
        if (m_done && exp_q.size() > 0) void'(exp_q.pop_back());
        m_done = 0; m_yv = 0; m_ov = 0; m_acc = 0; m_cnt = 0;
      end else if (!m_done) begin
        if (in_valid) begin
          m_y  = int'(a) + int'(b);
          m_yv = 1;
          m_acc = m_acc + m_y;
          if (m_cnt == COUNT - 1) begin
            m_acc_out = m_acc;
            exp_q.push_back(ACC_W'(m_acc));
            m_cnt  = 0;
            m_done = 1;
            m_ov   = 1;
          end else begin
            m_cnt = m_cnt + 1;
          end
        end else begin
          m_yv = 0;
        end
      end else begin
        m_yv = 0;
        if (out_ready) begin
          hs     = 1;
          hs_val = (exp_q.size() > 0) ? int'(exp_q.pop_front()) : -1;
          blocks = blocks + 1;
          m_acc  = 0;
          m_done = 0;
          m_ov   = 0;
        end
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_cycle();
    check_val("y",          32'(y),          32'(m_y));
    check_val("y_valid",    32'(y_valid),    32'(m_yv));
    check_val("out_valid",  32'(out_valid),  32'(m_ov));
    check_val("in_ready",   32'(in_ready),   32'(!m_done));
    check_val("acc_out",    32'(acc_out),    32'(m_acc_out));
    check_val("sample_cnt", 32'(sample_cnt), 32'(m_cnt));
    check_val("state",      32'(state_dbg),  32'(m_done));
    if (hs) check_val("blk_total", 32'(acc_out), 32'(hs_val));
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    check_cycle();
  endtask

  task automatic send(input int va, input int vb);
    in_valid = 1'b1;
    a = IN_W'(va);
    b = IN_W'(vb);
    tick();
    in_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    @(posedge clk); @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    check_val("rst_y",       32'(y),          0);
    check_val("rst_out_val", 32'(out_valid),  0);
    check_val("rst_acc_out", 32'(acc_out),    0);
    check_val("rst_cnt",     32'(sample_cnt), 0);
    check_val("rst_in_rdy",  32'(in_ready),   1);

    // Single sample
    send(5, 5);
    check_val("y_5p5",    32'(y),          10);
    check_val("yv_5p5",   32'(y_valid),    1);
    check_val("cnt_5p5",  32'(sample_cnt), 1);
    check_val("ov_5p5",   32'(out_valid),  0);
    tick();
    check_val("yv_pulse", 32'(y_valid),    0);
    clear = 1'b1; tick(); clear = 1'b0;
    check_val("clr_cnt",  32'(sample_cnt), 0);

    // Eight back-to-back maximum pairs
    out_ready = 1'b1;
    in_valid  = 1'b1; a = 4'd15; b = 4'd15;
    for (int i = 0; i < COUNT; i++) begin
      tick();
      check_val("y_max", 32'(y), 30);
    end
    in_valid = 1'b0;
    check_val("ov_max",  32'(out_valid), 1);
    check_val("acc_max", 32'(acc_out),   240);
    check_val("ir_max",  32'(in_ready),  0);
    tick();
    check_val("ov_one_cycle", 32'(out_valid), 0);

    // Backpressured block: (1,2)..(8,9) sums to 80
    out_ready = 1'b0;
    for (int i = 1; i <= COUNT; i++) send(i, i + 1);
    in_valid = 1'b1; a = 4'd9; b = 4'd9;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val("hold_acc", 32'(acc_out),   80);
      check_val("hold_ov",  32'(out_valid), 1);
      check_val("hold_ir",  32'(in_ready),  0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check_val("rel_ov",  32'(out_valid), 0);
    check_val("rel_ir",  32'(in_ready),  1);

    // Clear drops the coincident sample and the partial block
    for (int i = 0; i < 3; i++) send(3, 4);
    clear = 1'b1; in_valid = 1'b1; a = 4'd7; b = 4'd7;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    check_val("clr_drop_cnt", 32'(sample_cnt), 0);
    check_val("clr_drop_yv",  32'(y_valid),    0);
    check_val("clr_drop_y",   32'(y),          7);
    for (int i = 0; i < COUNT; i++) send(1, 1);
    check_val("acc_after_clr", 32'(acc_out), 16);
    tick();

    // Asynchronous reset mid-block
    for (int i = 0; i < 5; i++) send(2, 2);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_val("arst_y",   32'(y),          0);
    check_val("arst_yv",  32'(y_valid),    0);
    check_val("arst_ov",  32'(out_valid),  0);
    check_val("arst_acc", 32'(acc_out),    0);
    check_val("arst_cnt", 32'(sample_cnt), 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < COUNT; i++) send(2, 3);
    check_val("acc_after_rst", 32'(acc_out), 40);
    tick();

    // Randomized blocks with input gaps and backpressure
    blocks = 0;
    for (int c = 0; c < 4000 && blocks < 20; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = IN_W'($urandom_range(0, 15));
      b         = IN_W'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    in_valid = 1'b0;
    check_val("rand_blocks", 32'(blocks), 20);
    out_ready = 1'b1;
    for (int c = 0; c < 4 && m_done; c++) tick();
    check_val("q_empty", 32'(exp_q.size()), 0);

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/add_block_accumulator.md
Name: add_block_accumulator

Overview:
- Downstream consumer of the 4-bit operand adder stage. Accepts (a, b) operand pairs over a valid/ready handshake and registers each per-sample sum y = a + b.
- Accumulates COUNT consecutive sums into one block total, then presents that total on an output valid/ready handshake.
- Sits between the stimulus/adder stage and any block-level checker or scoreboard.

Parameters:
- IN_W, 4: operand width.
- COUNT, 8: samples per block; must be at least 2.
- SUM_W, IN_W+1: per-sample sum width. Derived; do not override.
- ACC_W, SUM_W+$clog2(COUNT): accumulator width. Derived; holds COUNT*(2^(IN_W+1)-2) without overflow.

Ports:
- clk  in  1  system clock, rising-edge active.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous abort: discards the partial block and returns to ACCUM.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair.
- a  in  IN_W  operand a.
- b  in  IN_W  operand b.
- y  out  SUM_W  registered sum of the last accepted pair.
- y_valid  out  1  one-cycle pulse, asserted the cycle after an accept.
- out_valid  out  1  block total valid.
- out_ready  in  1  downstream accepts the block total.
- acc_out  out  ACC_W  block total.
- sample_cnt  out  $clog2(COUNT)  samples accepted in the current block.

Behaviour:
- Reset (rst_n low, asynchronous): state=ACCUM; y=0; y_valid=0; out_valid=0; acc_out=0; sample_cnt=0; internal accumulator=0. Outputs hold these values until the first clk edge after rst_n rises.
- Accept: in_valid && in_ready at a rising edge.
- All arithmetic is unsigned and zero-extended; no truncation at any width.
- States:
  - ACCUM: in_ready=1, out_valid=0.
    - On accept: y<=a+b; y_valid<=1 next cycle; acc<=acc+(a+b).
    - If sample_cnt==COUNT-1 on accept: acc_out<=acc+(a+b); sample_cnt<=0; go to DONE.
    - Otherwise on accept: sample_cnt<=sample_cnt+1.
    - No accept: everything holds; y_valid<=0.
  - DONE: in_ready=0, out_valid=1, acc_out held stable.
    - On out_ready: acc<=0; out_valid drops next cycle; go to ACCUM.
    - out_ready low: hold indefinitely. acc_out and out_valid must not change while out_valid=1 and out_ready=0.
- in_ready is a combinational decode of state only. It never depends on in_valid or out_ready, so there are no combinational paths from input to output handshake.
- Latency:
  - y: 1 cycle after accept.
  - acc_out/out_valid: 1 cycle after the COUNT-th accept.
  - Minimum block period: COUNT+1 cycles. One bubble cycle occurs in DONE even when out_ready is held high.
- clear (synchronous, priority over every other event):
  - acc<=0, sample_cnt<=0, state<=ACCUM, out_valid<=0, y_valid<=0.
  - A sample presented in the same cycle is dropped; y does not update.
  - clear in DONE discards the pending total. acc_out keeps its stale value but out_valid=0.
- Asserting rst_n mid-block gives immediate reset values; any partial block is lost.
- y keeps its last value when y_valid=0.
- The bench flags any X on y, acc_out or the handshakes after reset as an error.

Decomposition:
- Shared package add_pkg:
  - localparams IN_W, SUM_W, COUNT_DEFAULT.
  - typedef enum logic {ACCUM, DONE} acc_state_e.
  - typedefs operand_t (IN_W bits) and sum_t (SUM_W bits), also reused by the upstream adder stage and testbench tasks.
- One sub-module is natural: add_sum_reg. It is the registered a+b with y/y_valid and an enable. It is instantiated once here and reusable by the upstream stage.
- FSM, counter and accumulator stay in the top module.

Test Plan:
- After reset, a=5, b=5 with one in_valid pulse: y=10 with y_valid the following cycle; sample_cnt=1; out_valid=0.
- Eight back-to-back pairs a=15, b=15 with out_ready=1:
  - y=30 each sample.
  - out_valid high for exactly one cycle, one cycle after the 8th accept, with acc_out=240 (max, no overflow).
  - in_ready low that cycle.
- Pairs (1,2) through (8,9) with out_ready=0 for 5 cycles after completion:
  - acc_out=80 held stable; in_valid ignored (in_ready=0).
  - Releasing out_ready returns to ACCUM; the next block starts from 0.
- Three pairs of (3,4) (acc=21), then clear asserted together with in_valid on (7,7):
  - sample dropped; sample_cnt=0.
  - The following 8 pairs of (1,1) yield acc_out=16.
- rst_n pulled low asynchronously mid-block (between clock edges) after 5 samples:
  - all outputs zero immediately.
  - After release, 8 pairs of (2,3) yield acc_out=40.
- Randomized a, b via $urandom with random in_valid/out_ready gaps over 20 blocks: every acc_out matches the scoreboard sum of its 8 y values; no handshake-rule violations.
